// File: rtl/prog_loader.sv
// Byte-stream program loader: reads a 16-bit big-endian word count, then packs
// bytes into 32-bit big-endian words and writes them to instruction memory.
module prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    CNT_HI = 3'd0,
    CNT_LO = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            state;
  logic [15:0]       count, idx, nxt_count;
  logic [1:0]        bcnt;
  logic [31:0]       word, last_data;
  logic [ADDR_W-1:0] last_addr, cur_addr;
  logic              xfer;

  assign byte_ready   = (state == CNT_HI) || (state == CNT_LO) || (state == DATA);
  assign xfer         = byte_valid & byte_ready;
  assign nxt_count    = {count[15:8], byte_in};
  assign cur_addr     = ADDR_W'(BASE_ADDR) + idx[ADDR_W-1:0];

  // Reload squashes a pending write and releases nothing to the core that cycle.
  assign imem_we      = (state == WRITE) && !reload;
  assign imem_addr    = imem_we ? cur_addr : last_addr;
  assign imem_wdata   = imem_we ? word : last_data;
  assign core_rst     = (state != DONE) || reload;
  assign done         = (state == DONE);
  assign err          = (state == ERR);
  assign words_loaded = idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CNT_HI;
      count     <= '0;
      idx       <= '0;
      bcnt      <= '0;
      word      <= '0;
      last_addr <= '0;
      last_data <= '0;
    end else if (reload) begin
      state <= CNT_HI;
      bcnt  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        CNT_HI: if (xfer) begin
          count[15:8] <= byte_in;
          state       <= CNT_LO;
        end
        CNT_LO: if (xfer) begin
          count[7:0] <= byte_in;
          bcnt       <= '0;
          idx        <= '0;
          if (nxt_count == 16'd0)               state <= DONE;
          else if ({1'b0, nxt_count} > DEPTH)   state <= ERR;
          else                                  state <= DATA;
        end
        DATA: if (xfer) begin
          word <= {word[23:0], byte_in};
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) state <= WRITE;
        end
        WRITE: begin
          last_addr <= cur_addr;
          last_data <= word;
          idx       <= idx + 16'd1;
          state     <= (idx + 16'd1 == count) ? DONE : DATA;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: byte-stream model checked every cycle plus
// literal expectations for each load scenario.
module tb_prog_loader;
  localparam int AW    = 8;
  localparam int BASE  = 0;
  localparam int DEPTH = 1 << AW;

  logic          clk = 0, rst = 0;
  logic [7:0]    byte_in = 0;
  logic          byte_valid = 0, reload = 0;
  logic          byte_ready, imem_we, core_rst, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [15:0]   words_loaded;

  prog_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
    .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Model: bytes accepted since the load started, and whether a full word awaits its write.
  logic [7:0]    acc[$];
  bit            m_pend = 0;
  int            m_words = 0;
  logic [AW-1:0] m_last_a = '0;
  logic [31:0]   m_last_d = '0;
  logic          e_ready, e_we, e_crst, e_done, e_err;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_data;
  logic [15:0]   e_wl;

  logic [AW-1:0] wl_a[$];
  logic [31:0]   wl_d[$];
  logic [7:0]    txq[$];

  function automatic void calc();
    bit hdr = acc.size() >= 2;
    int cnt = hdr ? int'({acc[0], acc[1]}) : 0;
    int b;
    e_err   = hdr && cnt > DEPTH;
    e_done  = hdr && !m_pend && !e_err && (m_words == cnt);
    e_ready = !m_pend && !e_done && !e_err;
    e_we    = m_pend && !reload && rst;
    e_crst  = !e_done || reload;
    e_wl    = 16'(m_words);
    if (e_we) begin
      b      = 2 + 4 * m_words;
      e_addr = AW'(BASE + m_words);
      e_data = {acc[b], acc[b+1], acc[b+2], acc[b+3]};
    end else begin
      e_addr = m_last_a;
      e_data = m_last_d;
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      acc.delete(); m_pend = 0; m_words = 0; m_last_a = '0; m_last_d = '0;
    end else begin
      calc();
      if (reload) begin
        acc.delete(); m_pend = 0; m_words = 0;
      end else if (m_pend) begin
        m_last_a = e_addr; m_last_d = e_data; m_words++; m_pend = 0;
      end else if (e_ready && byte_valid) begin
        acc.push_back(byte_in);
        if (acc.size() >= 6 && (acc.size() - 2) % 4 == 0) m_pend = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    calc();
    n_chk++;
    if (byte_ready === e_ready && imem_we === e_we && imem_addr === e_addr &&
        imem_wdata === e_data && core_rst === e_crst && done === e_done &&
        err === e_err && words_loaded === e_wl)
      n_pass++;
    else
      $display("FAIL cycle t=%0t got/want: rdy %b/%b we %b/%b addr %h/%h data %h/%h crst %b/%b done %b/%b err %b/%b wl %0d/%0d",
               $time, byte_ready, e_ready, imem_we, e_we, imem_addr, e_addr, imem_wdata, e_data,
               core_rst, e_crst, done, e_done, err, e_err, words_loaded, e_wl);
    if (imem_we === 1'b1) begin
      wl_a.push_back(imem_addr);
      wl_d.push_back(imem_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reload();
    reload = 1;
    @(posedge clk); #1;
    reload = 0;
  endtask

  // Presents txq byte by byte; returns one edge after the last byte is taken.
  task automatic send(input bit rv);
    int i = 0, g = 0;
    bit v, r;
    while (i < txq.size() && g < 4000) begin
      v = rv ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_valid = v;
      byte_in    = txq[i];
      r          = byte_ready;
      @(posedge clk); #1;
      if (v && r) i++;
      g++;
    end
    byte_valid = 0;
    if (i < txq.size()) chk("send_timeout", i, txq.size());
  endtask

  int n0;

  initial begin
    wait_cyc(2);
    chk("rst_ready", byte_ready, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_data", imem_wdata, 0);
    chk("rst_crst", core_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wl", words_loaded, 0);
    rst = 1;
    wait_cyc(1);

    // two-word load, continuous valid
    n0 = wl_a.size();
    txq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h10};
    send(0);
    wait_cyc(2);
    chk("two_nwr", wl_a.size() - n0, 2);
    chk("two_a0", wl_a[n0], 0);
    chk("two_d0", wl_d[n0], 32'h20080005);
    chk("two_a1", wl_a[n0+1], 1);
    chk("two_d1", wl_d[n0+1], 32'hAC080010);
    chk("two_done", done, 1);
    chk("two_crst", core_rst, 0);
    chk("two_wl", words_loaded, 2);
    chk("two_hold", imem_wdata, 32'hAC080010);

    // empty program
    do_reload();
    n0 = wl_a.size();
    txq = '{8'h00, 8'h00};
    send(0);
    chk("zero_done", done, 1);
    chk("zero_crst", core_rst, 0);
    wait_cyc(2);
    chk("zero_nwr", wl_a.size() - n0, 0);

    // count one past memory depth
    do_reload();
    n0 = wl_a.size();
    txq = '{8'h01, 8'h01};
    send(0);
    chk("big_err", err, 1);
    chk("big_ready", byte_ready, 0);
    chk("big_crst", core_rst, 1);
    wait_cyc(3);
    chk("big_hold", err, 1);
    chk("big_nwr", wl_a.size() - n0, 0);
    do_reload();
    chk("big_rl_err", err, 0);
    chk("big_rl_ready", byte_ready, 1);

    // three words, random valid
    n0 = wl_a.size();
    txq = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
            8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send(1);
    wait_cyc(2);
    chk("rnd_nwr", wl_a.size() - n0, 3);
    chk("rnd_d0", wl_d[n0], 32'h11223344);
    chk("rnd_d1", wl_d[n0+1], 32'h55667788);
    chk("rnd_d2", wl_d[n0+2], 32'hDEADBEEF);
    chk("rnd_a2", wl_a[n0+2], 2);
    chk("rnd_wl", words_loaded, 3);

    // async reset mid-word
    do_reload();
    txq = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send(0);
    rst = 0;
    #1;
    chk("mid_ready", byte_ready, 1);
    chk("mid_we", imem_we, 0);
    chk("mid_addr", imem_addr, 0);
    chk("mid_data", imem_wdata, 0);
    chk("mid_crst", core_rst, 1);
    chk("mid_wl", words_loaded, 0);
    @(posedge clk); #1;
    rst = 1;
    n0 = wl_a.size();
    txq = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send(0);
    wait_cyc(2);
    chk("mid_nwr", wl_a.size() - n0, 1);
    chk("mid_a0", wl_a[n0], BASE);
    chk("mid_d0", wl_d[n0], 32'hCAFEBABE);

    // reload during the write cycle
    do_reload();
    n0 = wl_a.size();
    txq = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
    send(0);
    reload = 1;
    #1;
    chk("rlw_we", imem_we, 0);
    chk("rlw_crst", core_rst, 1);
    @(posedge clk); #1;
    reload = 0;
    chk("rlw_wl", words_loaded, 0);
    chk("rlw_ready", byte_ready, 1);
    wait_cyc(2);
    chk("rlw_nwr", wl_a.size() - n0, 0);

    // count equal to memory depth fills every word
    do_reload();
    n0 = wl_a.size();
    txq = '{8'h01, 8'h00};
    for (int i = 0; i < DEPTH; i++) begin
      txq.push_back(8'(i));
      txq.push_back(8'hA5);
      txq.push_back(~8'(i));
      txq.push_back(8'h3C);
    end
    send(0);
    wait_cyc(2);
    chk("full_nwr", wl_a.size() - n0, DEPTH);
    chk("full_err", err, 0);
    chk("full_done", done, 1);
    chk("full_wl", words_loaded, DEPTH);
    chk("full_alast", wl_a[n0+DEPTH-1], 8'hFF);
    chk("full_dlast", wl_d[n0+DEPTH-1], 32'hFFA5003C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
